// File: rtl/md_pkg.sv
// Shared op codes and constants for the multiply/divide unit.
package md_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;
   localparam logic [2:0] MD_MADD  = 3'd6;
   localparam logic [2:0] MD_MADDU = 3'd7;

   localparam int MD_CNT_W = 4;

   localparam logic [31:0] MD_DIVZ_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/md_div.sv
// Combinational signed/unsigned 32-bit divide with MIPS-style zero and overflow results.
// Zero latency, no flow control; swappable for an iterative divider later.
module md_div
   import md_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        is_signed,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic        neg_a;
   logic        neg_b;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] uq;
   logic [31:0] ur;

   // Divide magnitudes, then restore signs: truncation toward zero, remainder follows dividend.
   assign neg_a = is_signed & a[31];
   assign neg_b = is_signed & b[31];
   assign mag_a = neg_a ? (32'd0 - a) : a;
   assign mag_b = neg_b ? (32'd0 - b) : b;
   assign uq    = mag_a / mag_b;
   assign ur    = mag_a % mag_b;

   always_comb begin
      quotient  = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
      remainder = neg_a ? (32'd0 - ur) : ur;
      if (b == 32'd0) begin
         quotient  = MD_DIVZ_Q;
         remainder = a;
      end else if (is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
         quotient  = 32'h8000_0000;
         remainder = 32'd0;
      end
   end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning HI/LO; results commit after MULT_CYCLES/DIV_CYCLES, busy stalls D.
// start is ignored while busy; optional MADD/MADDU accumulate under macro MD_MADD_EN.
module md_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   logic [MD_CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]         hi_q, hi_d;
   logic [31:0]         lo_q, lo_d;
   logic [31:0]         pend_hi_q, pend_hi_d;
   logic [31:0]         pend_lo_q, pend_lo_d;

   logic signed [63:0]  prod_s;
   logic [63:0]         prod_u;
   logic [31:0]         div_q;
   logic [31:0]         div_r;

   assign prod_s = $signed(a) * $signed(b);
   assign prod_u = {32'd0, a} * {32'd0, b};

   md_div u_div (
      .a         (a),
      .b         (b),
      .is_signed (op == MD_DIV),
      .quotient  (div_q),
      .remainder (div_r)
   );

`ifdef MD_MADD_EN
   logic [63:0] acc_s;
   logic [63:0] acc_u;
   assign acc_s = {hi_q, lo_q} + prod_s;
   assign acc_u = {hi_q, lo_q} + prod_u;
`endif

   always_comb begin
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == MD_CNT_W'(1)) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
         end
      end else if (start) begin
         case (op)
            MD_MULT: begin
               {pend_hi_d, pend_lo_d} = prod_s;
               cnt_d = MD_CNT_W'(MULT_CYCLES);
            end
            MD_MULTU: begin
               {pend_hi_d, pend_lo_d} = prod_u;
               cnt_d = MD_CNT_W'(MULT_CYCLES);
            end
            MD_DIV, MD_DIVU: begin
               pend_hi_d = div_r;
               pend_lo_d = div_q;
               cnt_d     = MD_CNT_W'(DIV_CYCLES);
            end
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
`ifdef MD_MADD_EN
            MD_MADD: begin
               {pend_hi_d, pend_lo_d} = acc_s;
               cnt_d = MD_CNT_W'(MULT_CYCLES);
            end
            MD_MADDU: begin
               {pend_hi_d, pend_lo_d} = acc_u;
               cnt_d = MD_CNT_W'(MULT_CYCLES);
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
      end
   end

   assign busy = (cnt_q != '0);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (default parameters, either MD_MADD_EN setting).
module tb_md_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   md_unit dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   // Issue one op for one cycle, then count cycles with busy high (sampled on negedge).
   task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int nbusy);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
      nbusy = 0;
      while (busy && nbusy < 40) begin
         nbusy++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
      checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 32'h8000_0000; b = 32'd2;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
      #2 rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_async_busy got %b want 0", busy); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after got %b want 0", busy); end
      checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL rstmid_hilo got %h want 0", {hi, lo}); end
   endtask

   task automatic test_mult;
      int n;
      do_op(3'd0, 32'h8000_0000, 32'd2, n);
      checks++; if (n !== 5) begin errors++; $display("FAIL mult_busy_cycles got %0d want 5", n); end
      checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
      checks++; if (lo !== 32'd0) begin errors++; $display("FAIL mult_lo got %h want 0", lo); end
      do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
      checks++; if (n !== 5) begin errors++; $display("FAIL multu_busy_cycles got %0d want 5", n); end
      checks++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL multu_hilo got %h want fffffffe00000001", {hi, lo}); end
      do_op(3'd0, 32'hFFFF_FFFD, 32'd7, n);
      checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mult_neg got %h want ffffffffffffffeb", {hi, lo}); end
   endtask

   task automatic test_div;
      int n;
      do_op(3'd2, 32'hFFFF_FFF9, 32'd2, n);
      checks++; if (n !== 10) begin errors++; $display("FAIL div_busy_cycles got %0d want 10", n); end
      checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", lo); end
      checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", hi); end
      do_op(3'd2, 32'd7, 32'hFFFF_FFFE, n);
      checks++; if ({hi, lo} !== {32'd1, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_negdivisor got %h want 00000001fffffffd", {hi, lo}); end
      do_op(3'd3, 32'd100, 32'd7, n);
      checks++; if (n !== 10) begin errors++; $display("FAIL divu_busy_cycles got %0d want 10", n); end
      checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_hilo got %h want 000000020000000e", {hi, lo}); end
      do_op(3'd3, 32'hFFFF_FFF9, 32'd2, n);
      checks++; if ({hi, lo} !== {32'd1, 32'h7FFF_FFFC}) begin errors++; $display("FAIL divu_big got %h want 000000017ffffffc", {hi, lo}); end
   endtask

   task automatic test_div_special;
      int n;
      do_op(3'd3, 32'd123, 32'd0, n);
      checks++; if ({hi, lo} !== {32'd123, 32'hFFFF_FFFF}) begin errors++; $display("FAIL divu_zero got %h want 0000007bffffffff", {hi, lo}); end
      do_op(3'd2, 32'hFFFF_FF00, 32'd0, n);
      checks++; if ({hi, lo} !== {32'hFFFF_FF00, 32'hFFFF_FFFF}) begin errors++; $display("FAIL div_zero got %h want ffffff00ffffffff", {hi, lo}); end
      do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
      checks++; if ({hi, lo} !== {32'd0, 32'h8000_0000}) begin errors++; $display("FAIL div_overflow got %h want 0000000080000000", {hi, lo}); end
   endtask

   task automatic test_mthi_mtlo;
      int n;
      logic [31:0] lo_before;
      lo_before = lo;
      do_op(3'd4, 32'hDEAD_BEEF, 32'd0, n);
      checks++; if (n !== 0) begin errors++; $display("FAIL mthi_busy got %0d want 0", n); end
      checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_hi got %h want deadbeef", hi); end
      checks++; if (lo !== lo_before) begin errors++; $display("FAIL mthi_lo_kept got %h want %h", lo, lo_before); end
      do_op(3'd5, 32'h0000_1111, 32'd0, n);
      checks++; if ({hi, lo} !== {32'hDEAD_BEEF, 32'h0000_1111}) begin errors++; $display("FAIL mtlo_hilo got %h want deadbeef00001111", {hi, lo}); end
   endtask

   task automatic test_busy_ignore;
      int n;
      @(negedge clk);
      start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      repeat (2) begin @(negedge clk); n++; end
      start = 1'b1; op = 3'd5; a = 32'h5555_5555;
      @(negedge clk); n++;
      op = 3'd0; a = 32'd3; b = 32'd3;
      @(negedge clk); n++;
      start = 1'b0;
      checks++; if ({hi, lo} !== {32'hDEAD_BEEF, 32'h0000_1111}) begin errors++; $display("FAIL ignore_hilo_midrun got %h want deadbeef00001111", {hi, lo}); end
      while (busy && n < 40) begin @(negedge clk); n++; end
      checks++; if (n !== 11) begin errors++; $display("FAIL ignore_commit_cycle got %0d want 11", n); end
      checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL ignore_hilo_commit got %h want 000000020000000e", {hi, lo}); end
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0 || {hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL ignore_no_late_start got busy=%b hilo=%h want 0 000000020000000e", busy, {hi, lo}); end
   endtask

   task automatic test_madd;
      int n;
      do_op(3'd4, 32'd0, 32'd0, n);
      do_op(3'd5, 32'hFFFF_FFFF, 32'd0, n);
      do_op(3'd7, 32'd1, 32'd1, n);
`ifdef MD_MADD_EN
      checks++; if (n !== 5) begin errors++; $display("FAIL maddu_busy got %0d want 5", n); end
      checks++; if ({hi, lo} !== {32'd1, 32'd0}) begin errors++; $display("FAIL maddu_hilo got %h want 0000000100000000", {hi, lo}); end
      do_op(3'd6, 32'hFFFF_FFFF, 32'd1, n);
      checks++; if ({hi, lo} !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL madd_hilo got %h want 00000000ffffffff", {hi, lo}); end
`else
      checks++; if (n !== 0) begin errors++; $display("FAIL maddu_noop_busy got %0d want 0", n); end
      checks++; if ({hi, lo} !== {32'd0, 32'hFFFF_FFFF}) begin errors++; $display("FAIL maddu_noop_hilo got %h want 00000000ffffffff", {hi, lo}); end
      do_op(3'd6, 32'd5, 32'd5, n);
      checks++; if (n !== 0 || {hi, lo} !== {32'd0, 32'hFFFF_FFFF}) begin errors++; $display("FAIL madd_noop got busy=%0d hilo=%h want 0 00000000ffffffff", n, {hi, lo}); end
`endif
   endtask

   initial begin
      test_reset();
      test_reset_mid();
      test_mult();
      test_div();
      test_div_special();
      test_mthi_mtlo();
      test_busy_ignore();
      test_madd();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
